// File: rtl/float_maxpool_pkg.sv
// Shared constants and helpers for the float max-pooling stage.
// Window counter sizing lives here so tests and RTL agree on it.
`include "float_macros.vh"

package float_maxpool_pkg;

    localparam int POOL_SIZE_DEF = 4;

    // A one-element window still needs a one-bit counter.
    function automatic int cnt_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/float_macros.vh
// Shared float field macros for the matmul output path stages.
// Parameter list, element width, field slices and the canonical quiet NaN.
`ifndef FLOAT_MACROS_VH
`define FLOAT_MACROS_VH

`define FLOAT_PARAMS parameter int EXP_WIDTH = 8, parameter int FRAC_WIDTH = 23
`define FLOAT_WIDTH (1 + EXP_WIDTH + FRAC_WIDTH)

`define FLOAT_SIGN(x) (x[EXP_WIDTH+FRAC_WIDTH])
`define FLOAT_MAG(x) (x[EXP_WIDTH+FRAC_WIDTH-1:0])
`define FLOAT_EXP(x) (x[EXP_WIDTH+FRAC_WIDTH-1:FRAC_WIDTH])
`define FLOAT_FRAC(x) (x[FRAC_WIDTH-1:0])

`define FLOAT_QNAN {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(FRAC_WIDTH-1){1'b0}}}

`endif

// File: rtl/float_max.sv
// Combinational max of two sign-magnitude floats; ties keep a.
// Signed zeros compare equal, so -0 vs +0 also keeps a.
`include "float_macros.vh"

module float_max
    import float_maxpool_pkg::*;
#(
    `FLOAT_PARAMS
) (
    input  logic [`FLOAT_WIDTH-1:0] a,
    input  logic [`FLOAT_WIDTH-1:0] b,
    output logic [`FLOAT_WIDTH-1:0] max
);

    logic b_wins;

    always_comb begin
        b_wins = 1'b0;
        if (`FLOAT_MAG(a) == '0 && `FLOAT_MAG(b) == '0) begin
            b_wins = 1'b0;
        end else if (`FLOAT_SIGN(a) != `FLOAT_SIGN(b)) begin
            b_wins = `FLOAT_SIGN(a);
        end else if (!`FLOAT_SIGN(a)) begin
            b_wins = `FLOAT_MAG(b) > `FLOAT_MAG(a);
        end else begin
            b_wins = `FLOAT_MAG(b) < `FLOAT_MAG(a);
        end
    end

    assign max = b_wins ? b : a;

endmodule

// File: rtl/float_maxpool.sv
// Streaming max-pool over POOL_SIZE elements, early close on in_last.
// Optional FLOAT_MAXPOOL_NAN_EN: any NaN in a window yields canonical qNaN.
`include "float_macros.vh"

module float_maxpool
    import float_maxpool_pkg::*;
#(
    `FLOAT_PARAMS,
    parameter int POOL_SIZE = POOL_SIZE_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [`FLOAT_WIDTH-1:0] in,
    input  logic                    in_valid,
    input  logic                    in_last,
    output logic                    in_ready,
    output logic [`FLOAT_WIDTH-1:0] res,
    output logic                    res_valid,
    input  logic                    res_ready
);

    localparam int W  = `FLOAT_WIDTH;
    localparam int CW = cnt_bits(POOL_SIZE);

    logic [W-1:0]  acc;
    logic [CW-1:0] cnt;
    logic [W-1:0]  max_ai;
    logic [W-1:0]  cand;
    logic [W-1:0]  res_next;
    logic          accept;
    logic          closing;

    float_max #(
        .EXP_WIDTH (EXP_WIDTH),
        .FRAC_WIDTH(FRAC_WIDTH)
    ) u_max (
        .a  (acc),
        .b  (in),
        .max(max_ai)
    );

    // Stalled output blocks all input, closing or not.
    assign in_ready = !(res_valid && !res_ready);
    assign accept   = in_valid && in_ready;
    assign closing  = (cnt == CW'(POOL_SIZE - 1)) || in_last;
    assign cand     = (cnt == '0) ? in : max_ai;

`ifdef FLOAT_MAXPOOL_NAN_EN
    logic nan_seen;
    logic nan_in;

    assign nan_in = (`FLOAT_EXP(in) == {EXP_WIDTH{1'b1}})
                 && (`FLOAT_FRAC(in) != '0);

    always_comb begin
        res_next = cand;
        if (nan_seen || nan_in) begin
            res_next = `FLOAT_QNAN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nan_seen <= 1'b0;
        end else if (accept) begin
            nan_seen <= closing ? 1'b0 : (nan_seen || nan_in);
        end
    end
`else
    always_comb begin
        res_next = cand;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            cnt       <= '0;
            res       <= '0;
            res_valid <= 1'b0;
        end else if (accept && closing) begin
            res       <= res_next;
            res_valid <= 1'b1;
            cnt       <= '0;
        end else begin
            if (res_ready) begin
                res_valid <= 1'b0;
            end
            if (accept) begin
                acc <= cand;
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule
